// File: rtl/fp_stim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_stim_pkg : shared types for the FP operand stream sequencer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fp_stim_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fp_state_e;

   // Width of one IEEE-754 operand: sign + exponent + mantissa.
   function automatic int fp_w(input int exp_width, input int man_width);
      return 1 + exp_width + man_width;
   endfunction

   localparam int DEF_EXP_WIDTH  = 8;
   localparam int DEF_MAN_WIDTH  = 23;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_W          = 1 + DEF_EXP_WIDTH + DEF_MAN_WIDTH;

   // Beat layout for the default single-precision build; the top widens it.
   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] tuser;
      logic                      tlast;
      logic [DEF_W-1:0]          b;
      logic [DEF_W-1:0]          a;
   } fp_beat_t;

endpackage
`default_nettype wire

// File: rtl/fp_stream_skid2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_stream_skid2 : 2-entry beat FIFO with empty-bypass from ROM stage |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_stream_skid2
   import fp_stim_pkg::*;
#(
   parameter type BEAT_T = fp_beat_t
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  BEAT_T      in_beat,
   output logic       out_valid,
   input  logic       out_ready,
   output BEAT_T      out_beat,
   output logic       out_fire,
   output logic [1:0] count
);

   BEAT_T      mem [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] cnt;
   logic       pop;
   logic       push;
   logic       bypass;

   // When empty, the ROM output register is presented directly; if it is not
   // taken it is captured so the beat stays stable on the next cycle.
   always_comb begin
      out_valid = (cnt != 2'd0) || in_valid;
      out_beat  = '0;
      if (cnt != 2'd0) begin
         out_beat = mem[rd_ptr];
      end else if (in_valid) begin
         out_beat = in_beat;
      end
      out_fire = out_valid && out_ready;
      pop      = out_fire && (cnt != 2'd0);
      bypass   = out_fire && (cnt == 2'd0);
      push     = in_valid && !bypass;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign count = cnt;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (cnt == 2'd2)));

endmodule
`default_nettype wire

// File: rtl/fp_operand_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_operand_stream_ctrl : walks operand A/B ROMs, streams {B,A} beats |
// | Optional macro FP_STREAM_REPEAT_EN adds repeat_req (looped passes).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_operand_stream_ctrl
   import fp_stim_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int MAN_WIDTH  = 23,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_VEC    = 16,
   localparam int W         = fp_w(EXP_WIDTH, MAN_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef FP_STREAM_REPEAT_EN
   input  logic                  repeat_req,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_rd_addr,
   input  logic [W-1:0]          rom_a_dout,
   input  logic [W-1:0]          rom_b_dout,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [2*W-1:0]        m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [ADDR_WIDTH-1:0] m_axis_tuser
);

   // One extra counter bit so NUM_VEC == 2**ADDR_WIDTH does not alias to 0.
   localparam int                      CW        = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]           NUM_VEC_C = CW'(NUM_VEC);
   localparam logic [CW-1:0]           LAST_CNT  = CW'(NUM_VEC - 1);
   localparam logic [ADDR_WIDTH-1:0]   LAST_IDX  = ADDR_WIDTH'(NUM_VEC - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] tuser;
      logic                  tlast;
      logic [W-1:0]          b;
      logic [W-1:0]          a;
   } beat_t;

   fp_state_e             state;
   logic [CW-1:0]         issue_cnt;
   logic                  s1_valid;
   logic                  s2_valid;
   logic [ADDR_WIDTH-1:0] s2_addr;
   beat_t                 in_beat;
   beat_t                 out_beat;
   logic                  out_valid;
   logic                  out_fire;
   logic [1:0]            buf_cnt;
   logic                  issue;
   logic                  drain_empty;
   logic                  wrap_req;
   logic [2:0]            committed;
   logic [2:0]            released;

`ifdef FP_STREAM_REPEAT_EN
   assign wrap_req = repeat_req;
`else
   assign wrap_req = 1'b0;
`endif

   // Credit: stored beats plus reads still in the ROM pipeline may never
   // exceed the two buffer slots, counting the slot freed by this cycle's
   // handshake.
   always_comb begin
      in_beat.tuser = s2_addr;
      in_beat.tlast = (s2_addr == LAST_IDX);
      in_beat.b     = rom_b_dout;
      in_beat.a     = rom_a_dout;
      committed     = {1'b0, buf_cnt} + {2'b00, s1_valid} + {2'b00, s2_valid};
      released      = 3'd2 + {2'b00, out_fire};
      issue         = (state == RUN) && (issue_cnt < NUM_VEC_C) && (committed < released);
      drain_empty   = !s1_valid &&
                      (({1'b0, buf_cnt} + {2'b00, s2_valid}) == {2'b00, out_fire});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         issue_cnt   <= '0;
         rom_rd_addr <= '0;
         s1_valid    <= 1'b0;
         s2_valid    <= 1'b0;
         s2_addr     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         s1_valid <= issue;
         s2_valid <= s1_valid;
         s2_addr  <= rom_rd_addr;
         done     <= 1'b0;
         if (issue) begin
            rom_rd_addr <= issue_cnt[ADDR_WIDTH-1:0];
            if ((issue_cnt == LAST_CNT) && wrap_req) begin
               issue_cnt <= '0;
            end else begin
               issue_cnt <= issue_cnt + CW'(1);
            end
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  issue_cnt <= '0;
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               if (issue && (issue_cnt == LAST_CNT) && !wrap_req) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_empty) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   fp_stream_skid2 #(
      .BEAT_T(beat_t)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s2_valid),
      .in_beat  (in_beat),
      .out_valid(out_valid),
      .out_ready(m_axis_tready),
      .out_beat (out_beat),
      .out_fire (out_fire),
      .count    (buf_cnt)
   );

   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = {out_beat.b, out_beat.a};
   assign m_axis_tlast  = out_beat.tlast;
   assign m_axis_tuser  = out_beat.tuser;

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_stream_ctrl.sv
`default_nettype none
// Bench for fp_operand_stream_ctrl: a single-precision NUM_VEC=10 instance and
// a double-precision NUM_VEC=16 instance, each fed by registered ROM models.
module tb_fp_operand_stream_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        sp_start = 1'b0, sp_busy, sp_done, sp_valid, sp_ready = 1'b1, sp_last;
   logic [3:0]  sp_addr, sp_user;
   logic [31:0] sp_a, sp_b;
   logic [63:0] sp_data;
   logic        dp_start = 1'b0, dp_busy, dp_done, dp_valid, dp_ready = 1'b1, dp_last;
   logic [3:0]  dp_addr, dp_user;
   logic [63:0] dp_a, dp_b;
   logic [127:0] dp_data;
   logic        sp_rpt = 1'b0;

   logic [31:0] roma_sp [16];
   logic [31:0] romb_sp [16];
   logic [63:0] roma_dp [16];
   logic [63:0] romb_dp [16];

   fp_operand_stream_ctrl #(.EXP_WIDTH(8), .MAN_WIDTH(23), .ADDR_WIDTH(4), .NUM_VEC(10)) u_sp (
      .clk(clk), .rst(rst), .start(sp_start),
`ifdef FP_STREAM_REPEAT_EN
      .repeat_req(sp_rpt),
`endif
      .busy(sp_busy), .done(sp_done), .rom_rd_addr(sp_addr),
      .rom_a_dout(sp_a), .rom_b_dout(sp_b),
      .m_axis_tvalid(sp_valid), .m_axis_tready(sp_ready), .m_axis_tdata(sp_data),
      .m_axis_tlast(sp_last), .m_axis_tuser(sp_user)
   );

   fp_operand_stream_ctrl #(.EXP_WIDTH(11), .MAN_WIDTH(52), .ADDR_WIDTH(4), .NUM_VEC(16)) u_dp (
      .clk(clk), .rst(rst), .start(dp_start),
`ifdef FP_STREAM_REPEAT_EN
      .repeat_req(1'b0),
`endif
      .busy(dp_busy), .done(dp_done), .rom_rd_addr(dp_addr),
      .rom_a_dout(dp_a), .rom_b_dout(dp_b),
      .m_axis_tvalid(dp_valid), .m_axis_tready(dp_ready), .m_axis_tdata(dp_data),
      .m_axis_tlast(dp_last), .m_axis_tuser(dp_user)
   );

   initial begin
      for (int i = 0; i < 16; i++) begin
         roma_sp[i] = 32'h3f80_0000 + 32'(i);
         romb_sp[i] = 32'h4000_0000 + 32'(i << 8);
         roma_dp[i] = 64'h3ff0_0000_0000_0000 + 64'(i);
         romb_dp[i] = {32'hc000_0000 + 32'(i), 32'h0000_0000};
      end
      romb_sp[0]  = 32'h00f3_e301;
      romb_sp[7]  = 32'h7fc0_0000;
      romb_sp[9]  = 32'h7f80_0000;
      romb_dp[10] = 64'he337_24c6_e337_24c6;
   end

   always @(posedge clk) begin
      sp_a <= roma_sp[sp_addr];
      sp_b <= romb_sp[sp_addr];
      dp_a <= roma_dp[dp_addr];
      dp_b <= romb_dp[dp_addr];
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [127:0] exp_data(input int i, input int idx);
      if (i == 0) return {64'd0, romb_sp[idx], roma_sp[idx]};
      return {romb_dp[idx], roma_dp[idx]};
   endfunction

   // Uniform views of both instances for the compare process.
   logic         v_valid [2], v_ready [2], v_last [2], v_done [2], v_busy [2], v_start [2];
   logic [3:0]   v_user  [2];
   logic [127:0] v_data  [2];
   always_comb begin
      v_valid[0] = sp_valid; v_ready[0] = sp_ready; v_last[0] = sp_last;
      v_done[0]  = sp_done;  v_busy[0]  = sp_busy;  v_start[0] = sp_start;
      v_user[0]  = sp_user;  v_data[0]  = {64'd0, sp_data};
      v_valid[1] = dp_valid; v_ready[1] = dp_ready; v_last[1] = dp_last;
      v_done[1]  = dp_done;  v_busy[1]  = dp_busy;  v_start[1] = dp_start;
      v_user[1]  = dp_user;  v_data[1]  = dp_data;
   end

   // Behavioural model: a run is nvec*passes beats with indices 0..nvec-1 in
   // order; done pulses the cycle after the final handshake.
   int           nvec [2] = '{10, 16};
   int           exp_passes [2] = '{1, 1};
   int           exp_idx [2], pass_cnt [2], start_cyc [2], done_seen [2];
   bit           busy_m [2], done_m [2], hold_m [2], seen_first [2];
   logic [127:0] h_data [2];
   logic [3:0]   h_user [2];
   logic         h_last [2];
   int           ncyc = 0;

   initial begin
      for (int i = 0; i < 2; i++) begin
         exp_idx[i] = 0; pass_cnt[i] = 0; start_cyc[i] = 0; done_seen[i] = 0;
         busy_m[i] = 0; done_m[i] = 0; hold_m[i] = 0; seen_first[i] = 1;
      end
   end

   always @(negedge clk) begin
      ncyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            busy_m[i] = 0; done_m[i] = 0; hold_m[i] = 0; exp_idx[i] = 0; pass_cnt[i] = 0;
         end else begin
            bit fire, end_fire, nxt_done;
            fire = v_valid[i] && v_ready[i];
            if (v_done[i]) done_seen[i]++;
            chk($sformatf("done%0d", i), v_done[i], done_m[i]);
            chk($sformatf("busy%0d", i), v_busy[i], busy_m[i]);
            if (!busy_m[i]) chk($sformatf("idle_valid%0d", i), v_valid[i], 0);
            if (hold_m[i]) begin
               chk($sformatf("hold_valid%0d", i), v_valid[i], 1);
               chk($sformatf("hold_data%0d", i), v_data[i], h_data[i]);
               chk($sformatf("hold_user%0d", i), v_user[i], h_user[i]);
               chk($sformatf("hold_last%0d", i), v_last[i], h_last[i]);
            end
            if (v_valid[i]) begin
               if (!seen_first[i]) begin
                  chk($sformatf("latency%0d", i), ncyc - start_cyc[i], 3);
                  seen_first[i] = 1;
               end
               chk($sformatf("tuser%0d", i), v_user[i], exp_idx[i]);
               chk($sformatf("tdata%0d", i), v_data[i], exp_data(i, exp_idx[i]));
               chk($sformatf("tlast%0d", i), v_last[i], exp_idx[i] == nvec[i] - 1);
            end
            if (fire) begin
               if (i == 0 && exp_idx[i] == 0)
                  chk("pin_sp_beat0", v_data[0][63:0], {32'h00f3_e301, 32'h3f80_0000});
               if (i == 0 && exp_idx[i] == 7)
                  chk("pin_sp_beat7_b", v_data[0][63:32], 32'h7fc0_0000);
               if (i == 0 && exp_idx[i] == 9) begin
                  chk("pin_sp_beat9_b", v_data[0][63:32], 32'h7f80_0000);
                  chk("pin_sp_beat9_last", v_last[0], 1);
                  chk("pin_sp_beat9_user", v_user[0], 9);
               end
               if (i == 1 && exp_idx[i] == 10)
                  chk("pin_dp_beat10_b", v_data[1][127:64], 64'he337_24c6_e337_24c6);
            end
            hold_m[i] = v_valid[i] && !fire;
            h_data[i] = v_data[i]; h_user[i] = v_user[i]; h_last[i] = v_last[i];
            end_fire = fire && (exp_idx[i] == nvec[i] - 1) && (pass_cnt[i] + 1 == exp_passes[i]);
            nxt_done = end_fire;
            if (v_start[i] && !busy_m[i] && !done_m[i]) begin
               busy_m[i] = 1; start_cyc[i] = ncyc; seen_first[i] = 0;
               exp_idx[i] = 0; pass_cnt[i] = 0;
            end else if (end_fire) begin
               busy_m[i] = 0;
            end
            if (fire) begin
               if (exp_idx[i] == nvec[i] - 1) begin
                  exp_idx[i] = 0; pass_cnt[i]++;
               end else begin
                  exp_idx[i]++;
               end
            end
            done_m[i] = nxt_done;
         end
      end
   end

   int rmode [2] = '{0, 0};
   int phase = 0;

   task automatic tick();
      @(posedge clk); #1;
      phase++;
      sp_ready = (rmode[0] == 0) ? 1'b1 : (rmode[0] == 1) ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b0;
      dp_ready = (rmode[1] == 0) ? 1'b1 : (rmode[1] == 1) ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b0;
   endtask

   task automatic wait_done(input int i, input int limit);
      bit got = 0;
      for (int k = 0; k < limit; k++) begin
         tick();
         if ((i == 0) ? sp_done : dp_done) begin
            got = 1;
            break;
         end
      end
      chk($sformatf("run_done%0d", i), got, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_valid", sp_valid, 0);
      chk("reset_busy", sp_busy, 0);
      chk("reset_done", sp_done, 0);
      chk("reset_addr", sp_addr, 0);
      chk("reset_tdata", sp_data, 0);
      chk("reset_tuser", sp_user, 0);
      chk("reset_tlast", sp_last, 0);
      chk("reset_dp_tdata", dp_data, 0);
      repeat (2) tick();

      // Single-precision run; extra starts while busy and coincident with done.
      sp_start = 1'b1; tick(); sp_start = 1'b0;
      repeat (4) tick();
      sp_start = 1'b1; tick(); sp_start = 1'b0;
      wait_done(0, 200);
      sp_start = 1'b1; tick(); sp_start = 1'b0;
      repeat (20) tick();
      chk("sp_done_count", done_seen[0], 1);

      // Double precision with tready 1,0,0,1 backpressure.
      rmode[1] = 1;
      dp_start = 1'b1; tick(); dp_start = 1'b0;
      wait_done(1, 400);
      repeat (10) tick();
      chk("dp_done_count", done_seen[1], 1);
      rmode[1] = 0;

      // Reset while beat 5 is stalled, then a fresh run.
      sp_start = 1'b1; tick(); sp_start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (sp_valid && sp_user == 4'd5) break;
         tick();
      end
      chk("rst_seen_beat5", sp_user, 5);
      rmode[0] = 2; sp_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_abort_valid", sp_valid, 0);
      chk("rst_abort_busy", sp_busy, 0);
      chk("rst_abort_done", sp_done, 0);
      repeat (5) tick();
      chk("rst_no_done", done_seen[0], 1);
      rmode[0] = 0;
      tick();
      sp_start = 1'b1; tick(); sp_start = 1'b0;
      wait_done(0, 200);
      repeat (5) tick();
      chk("sp_done_count2", done_seen[0], 2);

`ifdef FP_STREAM_REPEAT_EN
      // Three passes: repeat drops midway through the third.
      exp_passes[0] = 3;
      sp_rpt = 1'b1;
      sp_start = 1'b1; tick(); sp_start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (pass_cnt[0] == 2 && exp_idx[0] >= 4) break;
         tick();
      end
      sp_rpt = 1'b0;
      wait_done(0, 200);
      repeat (5) tick();
      chk("rpt_done_count", done_seen[0], 3);
      exp_passes[0] = 1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
